// File: rtl/lt100_lsu_if.sv
// CPU-side request/response port and LSU-to-bus port of lt100_lsu.
// CPU side: master = CPU, slave = LSU. Bus side: master = LSU, slave = lt100_bus.
interface lt100_lsu_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_err;

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lt100_bus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    enable;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output enable, wr_en, addr, wdata, be,
        input  ready, rdata, err
    );
    modport slave (
        input  enable, wr_en, addr, wdata, be,
        output ready, rdata, err
    );
endinterface

// File: rtl/lt100_lsu.sv
// Load/store unit: one CPU request at a time onto the lt100 enable/ready bus.
// Optional bus timeout enabled by defining LT100_LSU_TIMEOUT_EN.
module lt100_lsu #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    lt100_lsu_if.slave  cpu,
    lt100_bus_if.master bus
);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_e;
    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_BUS   = 2'd2,
        ERR_TMO   = 2'd3
    } err_e;

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
        $error("lt100_lsu: unsupported parameter values");
    end

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    err_e                  rsp_err_q, rsp_err_d;
    logic                  bus_enable_q, bus_enable_d;
    logic                  bus_wr_en_q, bus_wr_en_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]       bus_be_q, bus_be_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  illegal_c;
`ifdef LT100_LSU_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Right-justify load data and extend to full width.
    function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [1:0] size,
                                                       input logic sgn,
                                                       input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (size)
            2'd0:    r = {{(DATA_WIDTH-8){sgn & d[7]}}, d[7:0]};
            2'd1:    r = {{(DATA_WIDTH-16){sgn & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [BE_W-1:0] size_be(input logic [1:0] size);
        logic [BE_W-1:0] r;
        case (size)
            2'd0:    r = BE_W'(1);
            2'd1:    r = BE_W'(3);
            default: r = '1;
        endcase
        return r;
    endfunction

    assign illegal_c = (cpu.req_size == 2'd3)
                    || (cpu.req_size == 2'd1 && cpu.req_addr[0])
                    || (cpu.req_size == 2'd2 && cpu.req_addr[1:0] != 2'b00);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = ERR_OK;
        bus_enable_d = bus_enable_q;
        bus_wr_en_d  = bus_wr_en_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
`ifdef LT100_LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu.req_valid && req_ready_q) begin
                    if (illegal_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_ALIGN;
                    end else begin
                        bus_enable_d = 1'b1;
                        bus_wr_en_d  = cpu.req_wr;
                        bus_addr_d   = cpu.req_addr;
                        bus_wdata_d  = cpu.req_wdata;
                        bus_be_d     = size_be(cpu.req_size);
                        size_d       = cpu.req_size;
                        sgn_d        = cpu.req_signed;
                        state_d      = ACTIVE;
`ifdef LT100_LSU_TIMEOUT_EN
                        cnt_d        = '0;
`endif
                    end
                end
            end
            ACTIVE: begin
`ifdef LT100_LSU_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // Error beats ready when both arrive together.
                if (bus.err) begin
                    bus_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = ERR_BUS;
                    state_d      = RELEASE;
                end else if (bus.ready) begin
                    bus_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = bus_wr_en_q ? '0 : fmt_load(size_q, sgn_q, bus.rdata);
                    state_d      = RELEASE;
                end
`ifdef LT100_LSU_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    bus_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = ERR_TMO;
                    state_d      = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!bus.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= ERR_OK;
            bus_enable_q <= 1'b0;
            bus_wr_en_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
`ifdef LT100_LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            bus_enable_q <= bus_enable_d;
            bus_wr_en_q  <= bus_wr_en_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
`ifdef LT100_LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign cpu.req_ready = req_ready_q;
    assign cpu.rsp_valid = rsp_valid_q;
    assign cpu.rsp_rdata = rsp_rdata_q;
    assign cpu.rsp_err   = rsp_err_q;
    assign bus.enable    = bus_enable_q;
    assign bus.wr_en     = bus_wr_en_q;
    assign bus.addr      = bus_addr_q;
    assign bus.wdata     = bus_wdata_q;
    assign bus.be        = bus_be_q;

endmodule

// File: tb/tb_lt100_lsu.sv
// Scoreboard bench for lt100_lsu: directed requests, behavioural bus, response monitor.
module tb_lt100_lsu;
    localparam int MODE_READY = 0;
    localparam int MODE_ERR   = 1;
    localparam int MODE_BOTH  = 2;
    localparam int MODE_HANG  = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
    } bx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lt100_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cpu ();
    lt100_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    lt100_lsu #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu.slave),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t exp_q[$];
    bx_t  bx_q[$];

    int          bus_mode = MODE_READY;
    int          bus_lat  = 1;
    logic [31:0] bus_data = 32'h0;

    int en_len      = 0;
    int last_en_len = 0;
    int en_rises    = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural bus: one-cycle ready/err pulse after bus_lat enable cycles.
    initial begin : bus_model
        int en_cnt;
        bx_t bx;
        en_cnt    = 0;
        bus.ready = 1'b0;
        bus.err   = 1'b0;
        bus.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || bus.ready || bus.err) begin
                bus.ready = 1'b0;
                bus.err   = 1'b0;
                en_cnt    = 0;
            end else if (bus.enable) begin
                en_cnt++;
                if (bus_mode != MODE_HANG && en_cnt == bus_lat) begin
                    if (bx_q.size() == 0) begin
                        chk("bus_unexpected_cycle", 32'd1, 32'd0);
                    end else begin
                        bx = bx_q.pop_front();
                        chk("bus_addr", bus.addr, bx.addr);
                        chk("bus_be", 32'(bus.be), 32'(bx.be));
                        chk("bus_wr_en", 32'(bus.wr_en), 32'(bx.wr));
                        chk("bus_wdata", bus.wdata, bx.wdata);
                    end
                    bus.rdata = bus_data;
                    bus.ready = (bus_mode != MODE_ERR);
                    bus.err   = (bus_mode != MODE_READY);
                end
            end else begin
                en_cnt = 0;
            end
        end
    end

    // Response scoreboard and enable-behaviour monitor.
    initial begin : monitor
        rsp_t e;
        logic prev_resp;
        logic prev_en;
        prev_resp = 1'b0;
        prev_en   = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(cpu.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", cpu.rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(cpu.rsp_err), 32'(e.err));
                end
            end
            if (prev_resp) chk("enable_drop_after_resp", 32'(bus.enable), 32'd0);
            prev_resp = bus.enable && (bus.ready || bus.err);
            if (bus.enable) begin
                if (!prev_en) begin
                    en_rises++;
                    en_len = 0;
                end
                en_len++;
            end else if (prev_en) begin
                last_en_len = en_len;
            end
            prev_en = bus.enable;
        end
    end

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                         input logic [3:0] exp_be, input logic exp_rsp, input logic exp_bus);
        int n;
        n = 0;
        while (cpu.req_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("req_ready_wait", 32'(cpu.req_ready), 32'd1);
        if (exp_rsp) exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        if (exp_bus) bx_q.push_back('{addr: addr, be: exp_be, wr: wr, wdata: wdata});
        cpu.req_valid  = 1'b1;
        cpu.req_wr     = wr;
        cpu.req_size   = size;
        cpu.req_signed = sgn;
        cpu.req_addr   = addr;
        cpu.req_wdata  = wdata;
        @(posedge clk);
        #1;
        cpu.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cpu.req_ready !== 1'b1) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending_rsp", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(cpu.req_ready), 32'd1);
    endtask

    initial begin : stim
        int rises;
        int hang_wait;
        cpu.req_valid  = 1'b0;
        cpu.req_wr     = 1'b0;
        cpu.req_size   = 2'd0;
        cpu.req_signed = 1'b0;
        cpu.req_addr   = 32'h0;
        cpu.req_wdata  = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", 32'(cpu.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(cpu.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", cpu.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(cpu.rsp_err), 32'd0);
        chk("rst_bus_enable", 32'(bus.enable), 32'd0);
        chk("rst_bus_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_bus_addr", bus.addr, 32'd0);
        chk("rst_bus_wdata", bus.wdata, 32'd0);
        chk("rst_bus_be", 32'(bus.be), 32'd0);

        // Word load.
        bus_mode = MODE_READY; bus_lat = 1; bus_data = 32'hDEAD_BEEF;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2'd0, 4'b1111, 1'b1, 1'b1);
        drain();
        chk("word_load_enable_len", 32'(last_en_len), 32'd1);

        // Byte loads, signed and unsigned.
        bus_data = 32'h0000_0080;
        issue(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'h0, 32'hFFFF_FF80, 2'd0, 4'b0001, 1'b1, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'h0, 32'h0000_0080, 2'd0, 4'b0001, 1'b1, 1'b1);
        drain();

        // Half loads with slower bus.
        bus_lat = 3; bus_data = 32'hAAAA_8001;
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'hFFFF_8001, 2'd0, 4'b0011, 1'b1, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 32'h0000_8001, 2'd0, 4'b0011, 1'b1, 1'b1);
        drain();
        chk("half_load_enable_len", 32'(last_en_len), 32'd3);

        // Illegal requests never reach the bus.
        rises = en_rises;
        issue(1'b1, 2'd1, 1'b0, 32'h2000_0001, 32'h1234, 32'h0, 2'd1, 4'b0000, 1'b1, 1'b0);
        chk("illegal_ready_kept", 32'(cpu.req_ready), 32'd1);
        issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 2'd1, 4'b0000, 1'b1, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0, 32'h0, 2'd1, 4'b0000, 1'b1, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        chk("illegal_no_bus_cycle", 32'(en_rises), 32'(rises));

        // Bus error two cycles into ACTIVE, then error and ready together.
        bus_lat = 2; bus_mode = MODE_ERR; bus_data = 32'h5555_AAAA;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0, 32'h0, 2'd2, 4'b1111, 1'b1, 1'b1);
        drain();
        bus_lat = 1; bus_mode = MODE_BOTH;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0034, 32'h0, 32'h0, 2'd2, 4'b1111, 1'b1, 1'b1);
        drain();

        // Back-to-back store then load.
        bus_mode = MODE_READY; bus_data = 32'h1234_5678;
        rises = en_rises;
        issue(1'b1, 2'd0, 1'b0, 32'h2000_0000, 32'h0000_0041, 32'h0, 2'd0, 4'b0001, 1'b1, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 32'h1234_5678, 2'd0, 4'b1111, 1'b1, 1'b1);
        drain();
        chk("b2b_two_bus_cycles", 32'(en_rises - rises), 32'd2);
        chk("b2b_bus_queue_empty", 32'(bx_q.size()), 32'd0);

`ifdef LT100_LSU_TIMEOUT_EN
        // Timeout after exactly TIMEOUT_CYCLES enable-high cycles.
        bus_mode = MODE_HANG;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 2'd3, 4'b1111, 1'b1, 1'b0);
        drain();
        chk("timeout_enable_len", 32'(last_en_len), 32'd8);
        hang_wait = 4;
`else
        hang_wait = 20;
`endif

        // Reset in the middle of a stalled bus cycle.
        bus_mode = MODE_HANG;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 2'd0, 4'b1111, 1'b0, 1'b0);
        repeat (hang_wait) @(posedge clk);
        #1;
        chk("hang_enable_high", 32'(bus.enable), 32'd1);
        chk("hang_req_ready_low", 32'(cpu.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_enable", 32'(bus.enable), 32'd0);
        chk("midrst_req_ready", 32'(cpu.req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(cpu.rsp_valid), 32'd0);
        repeat (5) @(posedge clk);

        // Recovery after reset.
        bus_mode = MODE_READY; bus_lat = 1; bus_data = 32'h0000_7F00;
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0004, 32'h0, 32'h0000_7F00, 2'd0, 4'b0011, 1'b1, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        chk("final_rsp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
